// File: rtl/v20_trap_ctrl_pkg.sv
// rtl/v20_trap_ctrl_pkg.sv - shared types and constants for the trapezoid peak sequencer
package v20_trap_ctrl_pkg;

    localparam int TRAP_DATA_W     = 16;
    localparam int TRAP_TS_W       = 32;
    localparam int TRAP_CNT_W      = 8;
    localparam int TRAP_FIFO_DEPTH = 4;
    localparam int TRAP_LOST_W     = 16;

    localparam logic [TRAP_LOST_W-1:0] TRAP_LOST_SAT = '1;

    typedef logic [2:0] trap_state_t;

    localparam trap_state_t ST_IDLE = 3'd0;
    localparam trap_state_t ST_ARM  = 3'd1;
    localparam trap_state_t ST_PEAK = 3'd2;
    localparam trap_state_t ST_HOLD = 3'd3;
    localparam trap_state_t ST_EMIT = 3'd4;

    typedef struct packed {
        logic                   pileup;
        logic [TRAP_DATA_W-1:0] amp;
        logic [TRAP_TS_W-1:0]   ts;
    } trap_evt_t;

endpackage

// File: rtl/trap_evt_fifo.sv
// rtl/trap_evt_fifo.sv - show-ahead event FIFO; head is read combinationally from storage
module trap_evt_fifo
    import v20_trap_ctrl_pkg::*;
#(
    parameter type evt_t = trap_evt_t,
    parameter int  DEPTH = TRAP_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  evt_t                   push_data_i,
    output logic                   full_o,
    input  logic                   pop_i,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output evt_t                   head_o
);

    localparam int AW = $clog2(DEPTH);

    evt_t          mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) begin
            wr_d = wr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/trap_peak_sequencer.sv
// rtl/trap_peak_sequencer.sv - turns trapezoid filter output into timestamped pulse-height events
module trap_peak_sequencer
    import v20_trap_ctrl_pkg::*;
#(
    parameter int SIZE_FILTER_DATA = TRAP_DATA_W,
    parameter int TS_WIDTH         = TRAP_TS_W,
    parameter int CNT_WIDTH        = TRAP_CNT_W,
    parameter int FIFO_DEPTH       = TRAP_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [SIZE_FILTER_DATA-1:0]   filt_data,
    input  logic [SIZE_FILTER_DATA-1:0]   cfg_threshold,
    input  logic [CNT_WIDTH-1:0]          cfg_window,
    input  logic [CNT_WIDTH-1:0]          cfg_holdoff,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [SIZE_FILTER_DATA-1:0]   evt_amp,
    output logic [TS_WIDTH-1:0]           evt_ts,
    output logic                          evt_pileup,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [TRAP_LOST_W-1:0]        lost_cnt
);

    typedef struct packed {
        logic                        pileup;
        logic [SIZE_FILTER_DATA-1:0] amp;
        logic [TS_WIDTH-1:0]         ts;
    } evt_t;

    trap_state_t                 state_q, state_d;
    logic [SIZE_FILTER_DATA-1:0] filt_q;
    logic [TS_WIDTH-1:0]         ts_q;
    logic                        enable_q;
    logic [SIZE_FILTER_DATA-1:0] thr_q, thr_d;
    logic [CNT_WIDTH-1:0]        win_q, win_d;
    logic [CNT_WIDTH-1:0]        hold_q, hold_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [SIZE_FILTER_DATA-1:0] max_q, max_d;
    logic [TS_WIDTH-1:0]         evt_ts_q, evt_ts_d;
    logic                        pileup_q, pileup_d;
    logic                        below_q, below_d;
    logic [TRAP_LOST_W-1:0]      lost_q, lost_d;

    logic                        en_rise;
    logic                        above;
    logic [CNT_WIDTH-1:0]        win_eff;
    logic [CNT_WIDTH-1:0]        hold_last;
    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    evt_t                        push_evt;
    evt_t                        head_evt;

    assign en_rise   = enable && !enable_q;
    assign above     = (filt_q > thr_q);
    assign win_eff   = (win_q == '0) ? CNT_WIDTH'(1) : win_q;
    assign hold_last = (hold_q == '0) ? '0 : (hold_q - CNT_WIDTH'(1));
    assign pop       = evt_valid && evt_ready;

    assign push_evt.pileup = pileup_q;
    assign push_evt.amp    = max_q;
    assign push_evt.ts     = evt_ts_q;

    always_comb begin
        state_d  = state_q;
        thr_d    = thr_q;
        win_d    = win_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        evt_ts_d = evt_ts_q;
        pileup_d = pileup_q;
        below_d  = below_q;
        lost_d   = lost_q;
        push     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_rise) begin
                    thr_d   = cfg_threshold;
                    win_d   = cfg_window;
                    hold_d  = cfg_holdoff;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (above) begin
                    evt_ts_d = ts_q;
                    max_d    = filt_q;
                    cnt_d    = CNT_WIDTH'(1);
                    pileup_d = 1'b0;
                    below_d  = 1'b0;
                    state_d  = ST_PEAK;
                end
            end
            ST_PEAK: begin
                // The trigger sample counts as the first of the window.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == win_eff) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    if (filt_q > max_q) begin
                        max_d = filt_q;
                    end
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (!above) begin
                        below_d = 1'b1;
                    end
                    if (below_q && above) begin
                        pileup_d = 1'b1;
                    end
                    if (cnt_q == hold_last) begin
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_EMIT: begin
                push = 1'b1;
                if (fifo_full && !pop && (lost_q != TRAP_LOST_SAT)) begin
                    lost_d = lost_q + TRAP_LOST_W'(1);
                end
                state_d = enable ? ST_ARM : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            filt_q   <= '0;
            ts_q     <= '0;
            enable_q <= 1'b0;
            thr_q    <= '0;
            win_q    <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            max_q    <= '0;
            evt_ts_q <= '0;
            pileup_q <= 1'b0;
            below_q  <= 1'b0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            filt_q   <= filt_data;
            ts_q     <= ts_q + TS_WIDTH'(1);
            enable_q <= enable;
            thr_q    <= thr_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            evt_ts_q <= evt_ts_d;
            pileup_q <= pileup_d;
            below_q  <= below_d;
            lost_q   <= lost_d;
        end
    end

    trap_evt_fifo #(
        .evt_t (evt_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (push),
        .push_data_i (push_evt),
        .full_o      (fifo_full),
        .pop_i       (pop),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .head_o      (head_evt)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_amp    = head_evt.amp;
    assign evt_ts     = head_evt.ts;
    assign evt_pileup = head_evt.pileup;
    assign busy       = (state_q == ST_PEAK) || (state_q == ST_HOLD) || (state_q == ST_EMIT);
    assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_trap_peak_sequencer.sv
// tb/tb_trap_peak_sequencer.sv - self-checking bench for trap_peak_sequencer
module tb_trap_peak_sequencer;

    localparam int DW = 16;
    localparam int TW = 32;
    localparam int CW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] filt_data = '0;
    logic [DW-1:0] cfg_threshold = '0;
    logic [CW-1:0] cfg_window = '0;
    logic [CW-1:0] cfg_holdoff = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [DW-1:0] evt_amp;
    logic [TW-1:0] evt_ts;
    logic          evt_pileup;
    logic          busy;
    logic [2:0]    fifo_level;
    logic [15:0]   lost_cnt;

    trap_peak_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .filt_data     (filt_data),
        .cfg_threshold (cfg_threshold),
        .cfg_window    (cfg_window),
        .cfg_holdoff   (cfg_holdoff),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_amp       (evt_amp),
        .evt_ts        (evt_ts),
        .evt_pileup    (evt_pileup),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .lost_cnt      (lost_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Timeline model: an event occupies busy slots k=1..W+H+1 after its trigger edge:
    // slots 1..W-1 extend the peak search, W+1..W+H are hold-off, W+H+1 emits.
    typedef struct {
        int       amp;
        bit [31:0] ts;
        bit       pile;
    } mevt_t;

    mevt_t     m_q[$];
    mevt_t     m_e;
    int        m_thr, m_win, m_hold, m_filt, m_k, m_peak, m_lost, mw, mh;
    bit        m_en_prev, m_armed, m_run, m_pile, m_below, mpop, mpush;
    bit [31:0] m_ts_ctr, m_evt_ts;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_thr = 0; m_win = 0; m_hold = 0; m_filt = 0; m_k = 0; m_peak = 0; m_lost = 0;
            m_en_prev = 0; m_armed = 0; m_run = 0; m_pile = 0; m_below = 0;
            m_ts_ctr = 0; m_evt_ts = 0;
        end else begin
            mw    = (m_win == 0) ? 1 : m_win;
            mh    = (m_hold == 0) ? 1 : m_hold;
            mpop  = (m_q.size() > 0) && evt_ready;
            mpush = 0;
            if (m_run) begin
                if (m_k <= mw + mh && !enable) begin
                    m_run = 0;
                    m_armed = 0;
                end else begin
                    if (m_k < mw) begin
                        if (m_filt > m_peak) m_peak = m_filt;
                    end else if (m_k > mw && m_k <= mw + mh) begin
                        if (m_below && m_filt > m_thr) m_pile = 1;
                        if (m_filt <= m_thr) m_below = 1;
                    end
                    if (m_k == mw + mh + 1) begin
                        mpush = 1;
                        m_run = 0;
                        m_armed = enable;
                    end
                    m_k++;
                end
            end else if (m_armed) begin
                if (!enable) begin
                    m_armed = 0;
                end else if (m_filt > m_thr) begin
                    m_run = 1; m_k = 1; m_peak = m_filt; m_evt_ts = m_ts_ctr;
                    m_pile = 0; m_below = 0;
                end
            end else if (enable && !m_en_prev) begin
                m_armed = 1;
                m_thr = int'(cfg_threshold); m_win = int'(cfg_window); m_hold = int'(cfg_holdoff);
            end
            if (mpop) void'(m_q.pop_front());
            if (mpush) begin
                if (m_q.size() < FD) begin
                    m_e.amp = m_peak; m_e.ts = m_evt_ts; m_e.pile = m_pile;
                    m_q.push_back(m_e);
                end else if (m_lost < 65535) begin
                    m_lost++;
                end
            end
            m_en_prev = enable;
            m_filt = int'(filt_data);
            m_ts_ctr = m_ts_ctr + 1;
        end
    end

    int        e_amp;
    bit [31:0] e_ts;
    bit        e_pile, ok;

    always @(negedge clk) begin
        if (!reset) begin
            n_tests++;
            ok = (evt_valid === (m_q.size() > 0)) && (busy === m_run) &&
                 (int'(fifo_level) == m_q.size()) && (int'(lost_cnt) == m_lost);
            e_amp = 0; e_ts = 0; e_pile = 0;
            if (m_q.size() > 0) begin
                e_amp = m_q[0].amp; e_ts = m_q[0].ts; e_pile = m_q[0].pile;
                ok = ok && (int'(evt_amp) == e_amp) && (evt_ts === e_ts) && (evt_pileup === e_pile);
            end
            if (!ok) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t valid=%0b/%0b busy=%0b/%0b level=%0d/%0d lost=%0d/%0d amp=%0d/%0d ts=%0d/%0d pile=%0b/%0b (actual/required)",
                         $time, evt_valid, (m_q.size() > 0), busy, m_run, fifo_level, m_q.size(),
                         lost_cnt, m_lost, evt_amp, e_amp, evt_ts, e_ts, evt_pileup, e_pile);
            end
        end
    end

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int busy_cycles = 0;
    always @(negedge clk) begin
        if (!reset && busy) busy_cycles++;
    end

    int seq[$];
    int t150;
    bit got150;
    int amps[$];
    int exp_amps[4] = '{310, 320, 330, 350};

    task automatic set_std(input int amp);
        seq.delete();
        seq.push_back(0); seq.push_back(50); seq.push_back(150); seq.push_back(amp);
        seq.push_back(250); seq.push_back(120); seq.push_back(80);
    endtask

    task automatic set_pile();
        seq.delete();
        seq.push_back(0); seq.push_back(50); seq.push_back(150); seq.push_back(300);
        seq.push_back(250); seq.push_back(120); seq.push_back(0); seq.push_back(80);
        seq.push_back(200); seq.push_back(200);
    endtask

    // Drives seq then zeros; index i is driven for cycle i of the pulse.
    task automatic play(input int tail, input int ready_at, input int drop_at);
        int n;
        n = seq.size() + tail;
        got150 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            filt_data = (i < seq.size()) ? DW'(seq[i]) : '0;
            if (ready_at >= 0) evt_ready = (i == ready_at);
            if (i == drop_at) enable = 1'b0;
            if (i < seq.size() && seq[i] == 150 && !got150) begin
                t150 = cyc;
                got150 = 1;
            end
        end
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", evt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_lost", lost_cnt, 0);
        reset = 1'b0;
        cfg_threshold = 100; cfg_window = 4; cfg_holdoff = 8;
        @(negedge clk); enable = 1'b1;
        repeat (2) @(negedge clk);

        busy_cycles = 0;
        set_std(300); play(14, -1, -1);
        check("single_level", fifo_level, 1);
        check("single_amp", evt_amp, 300);
        check("single_pileup", evt_pileup, 0);
        check("single_ts", evt_ts, t150 + 1);
        check("single_busy_cycles", busy_cycles, 13);
        pop_one();
        check("single_drained", fifo_level, 0);

        set_pile(); play(14, -1, -1);
        check("pile_level", fifo_level, 1);
        check("pile_amp", evt_amp, 300);
        check("pile_flag", evt_pileup, 1);
        pop_one();

        for (int i = 0; i < 5; i++) begin
            set_std(300 + 10 * i); play(14, -1, -1);
        end
        check("ovf_level", fifo_level, 4);
        check("ovf_lost", lost_cnt, 1);
        check("ovf_head", evt_amp, 300);

        set_std(350); play(14, 16, -1);
        check("fullpop_level", fifo_level, 4);
        check("fullpop_lost", lost_cnt, 1);
        check("fullpop_head", evt_amp, 310);

        amps.delete();
        evt_ready = 1'b1;
        for (int i = 0; i < 20 && evt_valid; i++) begin
            amps.push_back(int'(evt_amp));
            @(negedge clk);
        end
        evt_ready = 1'b0;
        check("drain_count", amps.size(), 4);
        for (int i = 0; i < amps.size() && i < 4; i++) begin
            check($sformatf("drain_amp%0d", i), amps[i], exp_amps[i]);
        end

        busy_cycles = 0;
        set_std(300); play(14, -1, 10);
        check("drop_busy_cycles", busy_cycles, 7);
        check("drop_level", fifo_level, 0);
        check("drop_busy_now", busy, 0);
        cfg_threshold = 500;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        busy_cycles = 0;
        set_std(300); play(14, -1, -1);
        check("hithr_busy_cycles", busy_cycles, 0);
        check("hithr_level", fifo_level, 0);

        enable = 1'b0;
        repeat (2) @(negedge clk);
        cfg_threshold = 100;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        set_std(300); play(14, -1, -1);
        check("prerst_level", fifo_level, 1);
        set_std(320);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            filt_data = DW'(seq[i]);
        end
        check("prerst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", evt_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_lost", lost_cnt, 0);
        check("midrst_amp", evt_amp, 0);
        check("midrst_ts", evt_ts, 0);
        check("midrst_pileup", evt_pileup, 0);
        filt_data = '0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); enable = 1'b1;
        repeat (2) @(negedge clk);
        set_std(300); play(14, -1, -1);
        check("postrst_level", fifo_level, 1);
        check("postrst_amp", evt_amp, 300);
        check("postrst_ts", evt_ts, t150 + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_peak_sequencer.md
Name: trap_peak_sequencer

Overview:
- Sequences the output of the trapezoidal shaping filter into discrete pulse-height events.
- Arms on a programmable threshold and captures the maximum over a flat-top window.
- Applies a hold-off with pile-up detection, then timestamps the event and queues it in a small show-ahead FIFO for a downstream reader on a valid/ready handshake.
- Sits directly after the filter, one instance per ADC channel.

Parameters:
SIZE_FILTER_DATA, 16, width of filter output and threshold
TS_WIDTH, 32, free-running timestamp width
CNT_WIDTH, 8, width of window/hold-off counters
FIFO_DEPTH, 4, event FIFO entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run control; rising edge latches configuration
filt_data  in  SIZE_FILTER_DATA  filter output, unsigned, one sample per clk
cfg_threshold  in  SIZE_FILTER_DATA  trigger level, strict greater-than
cfg_window  in  CNT_WIDTH  peak-search length in samples (0 treated as 1)
cfg_holdoff  in  CNT_WIDTH  hold-off length in samples (0 treated as 1)
evt_valid  out  1  FIFO head valid
evt_ready  in  1  reader accepts head
evt_amp  out  SIZE_FILTER_DATA  peak amplitude of head event
evt_ts  out  TS_WIDTH  trigger timestamp of head event
evt_pileup  out  1  pile-up flag of head event
busy  out  1  state is PEAK, HOLD or EMIT
fifo_level  out  clog2(FIFO_DEPTH)+1  stored events
lost_cnt  out  16  events dropped on full FIFO, saturating at 0xFFFF

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state: all outputs 0, state IDLE, FIFO empty, ts counter 0, config shadows 0.
- Input register: filt_q <= filt_data every cycle. All decisions use filt_q, giving 1 cycle of latency from filt_data.
- Timestamp: ts increments every clk and wraps modulo 2^TS_WIDTH.
- Configuration: on the enable 0->1 edge while in IDLE, shadow registers load cfg_*. Config changes at any other time are ignored.
- IDLE:
  - Go to ARM on the enable rising edge.
- ARM:
  - If enable=0, go to IDLE.
  - Else if filt_q > thr: set evt_ts_r=ts, max=filt_q, cnt=1, pileup=0, below=0; go to PEAK.
- PEAK:
  - Each cycle: max <= max(max, filt_q) and cnt++.
  - When cnt == max(window,1), go to HOLD with cnt=0. Total samples examined = window, including the trigger sample.
- HOLD:
  - Lasts max(holdoff,1) cycles.
  - If filt_q <= thr, set below=1.
  - If below=1 and filt_q > thr, set pileup=1 (sticky).
  - At the end of the count, go to EMIT.
- EMIT: one cycle.
  - Push {pileup, max, evt_ts_r} into the FIFO if not full.
  - If full, do not push; lost_cnt++ (saturating).
  - A pop in the same cycle frees space, so push is accepted.
  - Next state: ARM if enable=1, else IDLE.
- Enable drop: enable=0 in PEAK or HOLD aborts the event with no push and goes to IDLE next cycle.
- Threshold crossings: no retrigger while in PEAK, HOLD or EMIT; those crossings only affect pileup.
- FIFO:
  - Show-ahead: evt_* reflect the head combinationally from storage.
  - Pop on evt_valid & evt_ready.
  - Empty pop is ignored.
  - evt_* are held stable while evt_valid=1 and evt_ready=0.
  - Wrap-around pointers carry one extra bit for full/empty.
- Reset mid-operation: immediate return to reset state. In-flight and queued events are discarded; lost_cnt and ts are cleared.
- Arithmetic: unsigned compares only; max register is SIZE_FILTER_DATA wide, so no overflow is possible.

Decomposition:
- Package v20_trap_ctrl_pkg:
  - state enum {IDLE, ARM, PEAK, HOLD, EMIT}
  - packed struct trap_evt_t {pileup, amp, ts}
  - width constants and the lost_cnt saturation value
- Sub-module trap_evt_fifo:
  - parameterized by trap_evt_t and FIFO_DEPTH
  - ports push/full/pop/empty/level plus head data

Test Plan:
- Single pulse: thr=100, window=4, holdoff=8, filt_data 0,50,150,300,250,120,80,0... -> one event with amp=300, pileup=0, evt_ts = ts in the cycle filt_q=150; busy high for 4+8+1 cycles.
- Pile-up: same config, during HOLD filt_data goes 80 then 200 -> event pileup=1, amp from the first pulse only, no second event.
- FIFO overflow: evt_ready=0, five separated pulses -> fifo_level=4, lost_cnt=1, head holds the first event. Then evt_ready=1 -> four events drain in order.
- Full with simultaneous pop: FIFO full, EMIT coincides with evt_ready=1 -> push accepted, lost_cnt unchanged, level stays 4.
- Enable drop: deassert enable during HOLD -> no event, state IDLE. Re-enable with thr=500 -> new threshold in effect, and a pulse of 300 produces no trigger.
- Reset mid PEAK: assert reset asynchronously between edges -> all outputs 0 immediately, fifo_level=0, ts restarts at 0 after release.
